king_escape_scanner: RTL and testbench

KING_ESCAPE_SCANNER -- requirements
Module: king_escape_scanner

---
 rtl/king_escape_scanner_pkg.sv | 20 ++
 rtl/king_escape_scanner_check_checker.sv | 43 ++++
 rtl/king_escape_scanner.sv | 114 +++++++++++
 tb/tb_king_escape_scanner.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/king_escape_scanner_pkg.sv
// king_escape_scanner_pkg: slot layout, piece indices, direction tables and FSM encoding shared by the scanner
package king_escape_scanner_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SCAN, FINISH} state_t;
  localparam logic [3:0] OWN_SLOT_W = 4'd6;
  localparam logic [3:0] ENEMY_SLOT_W = 4'd0;
  localparam logic [3:0] PAWN = 4'd0, KNIGHT = 4'd1, BISHOP = 4'd2, ROOK = 4'd3, QUEEN = 4'd4, KING = 4'd5;
  localparam int DIR_OFF [8] = '{8, 9, 1, -7, -8, -9, -1, 7};
  localparam int DIR_DR [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  localparam int DIR_DF [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  localparam int KN_DR [8] = '{1, 2, 2, 1, -1, -2, -2, -1};
  localparam int KN_DF [8] = '{2, 1, -1, -2, -2, -1, 1, 2};
  // highest set bit wins, so multiple kings resolve to highest rank then file
  function automatic logic [5:0] king_sq(input logic [63:0] bb);
    king_sq = '0;
    for (int i = 0; i < 64; i++) if (bb[i]) king_sq = 6'(i);
  endfunction
  function automatic logic hit(input logic [63:0] bb, input int r, input int f);
    return (r >= 0 && r < 8 && f >= 0 && f < 8) ? bb[6'(r * 8 + f)] : 1'b0;
  endfunction
endpackage

// File: rtl/king_escape_scanner_check_checker.sv
// king_escape_scanner_check_checker: combinational test of whether the own king is attacked on a board
module king_escape_scanner_check_checker
  import king_escape_scanner_pkg::*;
(
  input  logic [767:0] board,
  input  logic         is_white,
  output logic         attacked
);
  logic [3:0] ob, eb;
  logic [63:0] occ, kb, ep, en, ek, erq, ebq, sl;
  logic [5:0] ks;
  logic att, blk;
  int r, f;
  always_comb begin
    ob = is_white ? OWN_SLOT_W : ENEMY_SLOT_W;
    eb = is_white ? ENEMY_SLOT_W : OWN_SLOT_W;
    occ = '0;
    for (int k = 0; k < 12; k++) occ |= board[{4'(k), 6'd0} +: 64];
    kb = board[{ob + KING, 6'd0} +: 64];
    ep = board[{eb + PAWN, 6'd0} +: 64];
    en = board[{eb + KNIGHT, 6'd0} +: 64];
    ek = board[{eb + KING, 6'd0} +: 64];
    erq = board[{eb + ROOK, 6'd0} +: 64] | board[{eb + QUEEN, 6'd0} +: 64];
    ebq = board[{eb + BISHOP, 6'd0} +: 64] | board[{eb + QUEEN, 6'd0} +: 64];
    ks = king_sq(kb);
    r = int'(ks[5:3]);
    f = int'(ks[2:0]);
    sl = '0;
    blk = 1'b0;
    // enemy pawns strike toward our side, so look one rank ahead of the king
    att = hit(ep, is_white ? r + 1 : r - 1, f - 1) | hit(ep, is_white ? r + 1 : r - 1, f + 1);
    for (int d = 0; d < 8; d++) begin
      att |= hit(en, r + KN_DR[d], f + KN_DF[d]) | hit(ek, r + DIR_DR[d], f + DIR_DF[d]);
      sl = (DIR_DR[d] == 0 || DIR_DF[d] == 0) ? erq : ebq;
      blk = 1'b0;
      for (int s = 1; s < 8; s++) begin
        att |= !blk & hit(sl, r + s * DIR_DR[d], f + s * DIR_DF[d]);
        blk |= hit(occ, r + s * DIR_DR[d], f + s * DIR_DF[d]);
      end
    end
    attacked = |kb & att;
  end
endmodule

// File: rtl/king_escape_scanner.sv
// king_escape_scanner: scans the unmodified board and all eight king steps for check, one candidate per cycle
module king_escape_scanner
  import king_escape_scanner_pkg::*;
#(
  parameter int NUM_DIRS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_white,
  input  logic [767:0] piece_bitboards_flattened,
  output logic         busy,
  output logic         done,
  output logic         in_check,
  output logic [7:0]   escape_mask,
  output logic         king_trapped,
  output logic         no_king
);
  state_t state_q, state_d;
  logic [767:0] board_q, scratch_d, s1_board_q;
  logic white_q, s1_valid_q, nok_q, chk, last;
  logic [5:0] ksq_q, ksq_d, tgt;
  logic [7:0] legal_q, legal_d, esc_d, chk_q, esc_q;
  logic [3:0] idx_q, s1_idx_q, own_b, en_b, own_k;
  logic [2:0] dsel;
  logic [63:0] own_occ, kbb;
  logic [8:0] chk_all;
  logic in_check_q, trapped_q, no_king_q;
  assign last = s1_valid_q && s1_idx_q == 4'd8;
  always_comb begin
    state_d = state_q == IDLE ? (start ? LOAD : IDLE) :
              state_q == LOAD ? SCAN :
              state_q == SCAN ? (last ? FINISH : SCAN) : IDLE;
    busy = state_q != IDLE;
    done = state_q == FINISH;
  end
  always_comb begin
    own_b = white_q ? OWN_SLOT_W : ENEMY_SLOT_W;
    en_b = white_q ? ENEMY_SLOT_W : OWN_SLOT_W;
    own_k = own_b + KING;
    own_occ = '0;
    for (int k = 0; k < 6; k++) own_occ |= board_q[{own_b + 4'(k), 6'd0} +: 64];
    kbb = board_q[{own_k, 6'd0} +: 64];
    ksq_d = king_sq(kbb);
    legal_d = '0;
    for (int d = 0; d < NUM_DIRS; d++)
      legal_d[d] = |kbb & hit(~own_occ, int'(ksq_d[5:3]) + DIR_DR[d], int'(ksq_d[2:0]) + DIR_DF[d]);
    dsel = 3'(idx_q - 4'd1);
    tgt = 6'(int'(ksq_q) + DIR_OFF[dsel]);
    scratch_d = board_q;
    // candidate 0 is the untouched board; illegal steps stay untouched and are masked later
    if (idx_q != 4'd0 && legal_q[dsel]) begin
      scratch_d[{own_k, ksq_q}] = 1'b0;
      for (int k = 0; k < 6; k++) scratch_d[{en_b + 4'(k), tgt}] = 1'b0;
      scratch_d[{own_k, tgt}] = 1'b1;
    end
    chk_all = {chk, chk_q};
    esc_d = '0;
    for (int d = 0; d < NUM_DIRS; d++) esc_d[d] = legal_q[d] & ~chk_all[d + 1];
  end
  king_escape_scanner_check_checker u_check_checker (
    .board(s1_board_q),
    .is_white(white_q),
    .attacked(chk)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      board_q <= '0;
      white_q <= 1'b0;
      ksq_q <= '0;
      legal_q <= '0;
      nok_q <= 1'b0;
      idx_q <= '0;
      s1_board_q <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q <= '0;
      chk_q <= '0;
      in_check_q <= 1'b0;
      esc_q <= '0;
      trapped_q <= 1'b0;
      no_king_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        board_q <= piece_bitboards_flattened;
        white_q <= is_white;
      end
      if (state_q == LOAD) begin
        ksq_q <= ksq_d;
        legal_q <= legal_d;
        nok_q <= ~|kbb;
        idx_q <= '0;
      end
      s1_valid_q <= state_q == SCAN && idx_q < 4'd9;
      if (state_q == SCAN && idx_q < 4'd9) begin
        s1_board_q <= scratch_d;
        s1_idx_q <= idx_q;
        idx_q <= idx_q + 4'd1;
      end
      if (s1_valid_q && s1_idx_q < 4'd8) chk_q[s1_idx_q[2:0]] <= chk;
      if (last) begin
        in_check_q <= chk_all[0];
        esc_q <= esc_d;
        trapped_q <= chk_all[0] & ~|esc_d;
        no_king_q <= nok_q;
      end
    end
  end
  assign in_check = in_check_q;
  assign escape_mask = esc_q;
  assign king_trapped = trapped_q;
  assign no_king = no_king_q;
endmodule

// File: tb/tb_king_escape_scanner.sv
// tb_king_escape_scanner: directed scans with a scoreboard of expected results checked on each done pulse
module tb_king_escape_scanner;
  typedef struct packed {logic ic; logic [7:0] m; logic tr; logic nk;} exp_t;
  logic clk = 1'b0;
  logic rst_n, start, is_white;
  logic [767:0] bb;
  logic busy, done, in_check, king_trapped, no_king;
  logic [7:0] escape_mask;
  int checks = 0, failures = 0, cyc = 0, t_start = 0;
  exp_t sb[$];
  king_escape_scanner dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_white(is_white),
    .piece_bitboards_flattened(bb), .busy(busy), .done(done), .in_check(in_check),
    .escape_mask(escape_mask), .king_trapped(king_trapped), .no_king(no_king)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [767:0] pc(input int slot, input int sq);
    logic [767:0] b;
    b = '0;
    b[10'(64 * slot + sq)] = 1'b1;
    return b;
  endfunction
  task automatic start_scan(input logic [767:0] b, input logic w, input exp_t e);
    @(negedge clk);
    bb = b;
    is_white = w;
    start = 1'b1;
    @(posedge clk);
    #1;
    t_start = cyc;
    sb.push_back(e);
    check("busy_after_start", int'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    bb = {24{$urandom}};
    is_white = ~w;
  endtask
  task automatic wait_done(input string tag);
    exp_t e;
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk);
      #1;
      seen = done;
    end
    check({tag, "_latency"}, seen ? cyc - t_start : -1, 11);
    check({tag, "_busy_done"}, int'(busy), 1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    check({tag, "_in_check"}, int'(in_check), int'(e.ic));
    check({tag, "_escape_mask"}, int'(escape_mask), int'(e.m));
    check({tag, "_king_trapped"}, int'(king_trapped), int'(e.tr));
    check({tag, "_no_king"}, int'(no_king), int'(e.nk));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_idle"}, int'(busy), 0);
  endtask
  initial begin
    logic [767:0] b019, b020, b021;
    int extra;
    b019 = pc(11, 0) | pc(5, 63);
    b020 = pc(11, 4) | pc(6, 11) | pc(6, 12) | pc(6, 13) | pc(3, 0) | pc(5, 63);
    b021 = pc(11, 0) | pc(4, 9) | pc(5, 63);
    rst_n = 1'b0;
    start = 1'b0;
    is_white = 1'b1;
    bb = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_in_check", int'(in_check), 0);
    check("rst_escape_mask", int'(escape_mask), 0);
    check("rst_king_trapped", int'(king_trapped), 0);
    check("rst_no_king", int'(no_king), 0);
    rst_n = 1'b1;
    start_scan(b019, 1'b1, '{1'b0, 8'h07, 1'b0, 1'b0});
    wait_done("corner_white");
    start_scan(pc(5, 63) | pc(11, 0), 1'b0, '{1'b0, 8'h70, 1'b0, 1'b0});
    wait_done("corner_black");
    start_scan(b020, 1'b1, '{1'b1, 8'h00, 1'b1, 1'b0});
    wait_done("rook_trap");
    start_scan(pc(11, 27) | pc(0, 36) | pc(5, 63), 1'b1, '{1'b1, 8'hff, 1'b0, 1'b0});
    wait_done("pawn_check");
    start_scan(pc(11, 0) | pc(1, 17) | pc(5, 63), 1'b1, '{1'b1, 8'h07, 1'b0, 1'b0});
    wait_done("knight_check");
    start_scan(pc(11, 0) | pc(6, 27) | pc(2, 63) | pc(5, 56), 1'b1, '{1'b0, 8'h07, 1'b0, 1'b0});
    wait_done("bishop_blocked");
    start_scan(pc(5, 63) | pc(3, 10), 1'b1, '{1'b0, 8'h00, 1'b0, 1'b1});
    wait_done("no_king");
    start_scan(b021, 1'b1, '{1'b1, 8'h02, 1'b0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    bb = b019;
    is_white = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("queen_restart_ignored");
    extra = 0;
    repeat (14) begin
      @(posedge clk);
      #1;
      extra += int'(done);
    end
    check("ignored_start_no_extra_done", extra, 0);
    start_scan(b019, 1'b1, '{1'b0, 8'h07, 1'b0, 1'b0});
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_in_check", int'(in_check), 0);
    check("abort_escape_mask", int'(escape_mask), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    extra = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      extra += int'(done);
    end
    check("abort_no_done", extra, 0);
    start_scan(b020, 1'b1, '{1'b1, 8'h00, 1'b1, 1'b0});
    wait_done("after_abort");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
